instruction_fetch_unit: RTL

Instruction fetch stage of the RV32IM 5-stage pipeline. Owns the program counter, issues word reads to the instruction memory over the READ/BUSYWAIT handshake, and drives the PC, PC+4 and instruction inputs of the IF/ID pipeline register. It absorbs multi-cycle memory latency, downstream stalls from the hazard unit, and branch/jump redirects from EX. It presents a NOP bubble whenever no valid instruction is available.

---
 rtl/instruction_fetch_unit_if.sv | 25 ++
 rtl/instruction_fetch_unit.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit_if.sv
// Instruction memory read port: word read request with BUSYWAIT back-pressure.
//   master (fetch unit): drives IMEM_READ, IMEM_ADDRESS; receives IMEM_READDATA, IMEM_BUSYWAIT
//   slave  (memory)    : the reverse directions
interface instruction_fetch_unit_if;
    localparam int unsigned XLEN = 32;

    logic            IMEM_READ;
    logic [XLEN-1:0] IMEM_ADDRESS;
    logic [XLEN-1:0] IMEM_READDATA;
    logic            IMEM_BUSYWAIT;

    modport master (
        output IMEM_READ,
        output IMEM_ADDRESS,
        input  IMEM_READDATA,
        input  IMEM_BUSYWAIT
    );

    modport slave (
        input  IMEM_READ,
        input  IMEM_ADDRESS,
        output IMEM_READDATA,
        output IMEM_BUSYWAIT
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: owns the PC, reads instruction memory and feeds IF/ID.
// Absorbs memory latency (BUSYWAIT), downstream stalls (single-entry buffer) and
// branch redirects (draining an in-flight read at its original address).
// Ports:
//   CLK, RESET        clock, synchronous active-high reset
//   STALL             IF/ID held; presented instruction must not advance
//   BRANCH_TAKEN      one-cycle redirect pulse, BRANCH_TARGET word address (bits[1:0] ignored)
//   imem              instruction memory read port (master side)
//   PC_OUT, PC_PLUS_FOUR_OUT, INSTRUCTION_OUT, INSTR_VALID
//                     IF/ID inputs; zeros and NOP when INSTR_VALID=0
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     STALL,
    input  logic                     BRANCH_TAKEN,
    input  logic [31:0]              BRANCH_TARGET,
    instruction_fetch_unit_if.master imem,
    output logic [31:0]              PC_OUT,
    output logic [31:0]              PC_PLUS_FOUR_OUT,
    output logic [31:0]              INSTRUCTION_OUT,
    output logic                     INSTR_VALID
);
    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] req_addr_q, req_addr_d;
    logic [XLEN-1:0] hold_instr_q, hold_instr_d;
    logic [XLEN-1:0] hold_pc_q, hold_pc_d;

    logic [XLEN-1:0] target_aligned;
    logic [XLEN-1:0] pc_plus_four;
    logic            imem_read_c;
    logic [XLEN-1:0] imem_addr_c;
    logic            sel_valid;
    logic [XLEN-1:0] sel_pc;
    logic [XLEN-1:0] sel_instr;
    logic            unused_target_lsbs;

    // Targets are forced to word alignment; the low bits carry no information.
    assign target_aligned     = {BRANCH_TARGET[XLEN-1:2], 2'b00};
    assign unused_target_lsbs = ^BRANCH_TARGET[1:0];
    assign pc_plus_four       = pc_q + XLEN'(4);

    // State register.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q      <= FETCH;
            pc_q         <= RESET_PC;
            req_addr_q   <= RESET_PC;
            hold_instr_q <= '0;
            hold_pc_q    <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            req_addr_q   <= req_addr_d;
            hold_instr_q <= hold_instr_d;
            hold_pc_q    <= hold_pc_d;
        end
    end

    // Next-state, memory request and presented-instruction selection.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        req_addr_d   = req_addr_q;
        hold_instr_d = hold_instr_q;
        hold_pc_d    = hold_pc_q;
        imem_read_c  = 1'b0;
        imem_addr_c  = pc_q;
        sel_valid    = 1'b0;
        sel_pc       = '0;
        sel_instr    = NOP_INSTR;

        case (state_q)
            FETCH: begin
                imem_read_c = 1'b1;
                req_addr_d  = pc_q;
                if (BRANCH_TAKEN) begin
                    // A busy read must finish at its old address before the target is issued.
                    pc_d = target_aligned;
                    if (imem.IMEM_BUSYWAIT) begin
                        state_d = DRAIN;
                    end
                end else if (!imem.IMEM_BUSYWAIT) begin
                    pc_d = pc_plus_four;
                    if (STALL) begin
                        hold_instr_d = imem.IMEM_READDATA;
                        hold_pc_d    = pc_q;
                        state_d      = HOLD;
                    end else begin
                        sel_valid = 1'b1;
                        sel_pc    = pc_q;
                        sel_instr = imem.IMEM_READDATA;
                    end
                end
            end

            HOLD: begin
                if (BRANCH_TAKEN) begin
                    pc_d    = target_aligned;
                    state_d = FETCH;
                end else begin
                    sel_valid = 1'b1;
                    sel_pc    = hold_pc_q;
                    sel_instr = hold_instr_q;
                    if (!STALL) begin
                        state_d = FETCH;
                    end
                end
            end

            DRAIN: begin
                // Keep the abandoned address stable until the memory lets go.
                imem_read_c = 1'b1;
                imem_addr_c = req_addr_q;
                if (BRANCH_TAKEN) begin
                    pc_d = target_aligned;
                end
                if (!imem.IMEM_BUSYWAIT) begin
                    state_d = FETCH;
                end
            end

            default: begin
                state_d = FETCH;
            end
        endcase

        if (RESET) begin
            imem_read_c = 1'b0;
            sel_valid   = 1'b0;
        end
    end

    assign imem.IMEM_READ    = imem_read_c;
    assign imem.IMEM_ADDRESS = imem_addr_c;

    assign INSTR_VALID      = sel_valid;
    assign INSTRUCTION_OUT  = sel_valid ? sel_instr : NOP_INSTR;
    assign PC_OUT           = sel_valid ? sel_pc : '0;
    assign PC_PLUS_FOUR_OUT = sel_valid ? (sel_pc + XLEN'(4)) : '0;
endmodule
